// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller and its BCD converter.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hf;
  localparam int          MAX_VALUE  = 9999;
  localparam int          BCD_W      = 16;
  localparam int          BIN_W      = 14;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Value handshake from the timer FSM into the scan controller.
// valid/ready: a transfer happens on a clock edge where i_valid and o_ready are both high;
// i_value must be stable while i_valid is high, and i_valid seen while o_ready is low is dropped.
interface fnd_scan_ctrl_if #(
  parameter int VALUE_W = 14
);
  logic [VALUE_W-1:0] i_value;
  logic               i_valid;
  logic               o_ready;

  modport master (output i_value, output i_valid, input  o_ready);
  modport slave  (input  i_value, input  i_valid, output o_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: 14 shift cycles after i_start, o_done flags the last shift.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  logic [BIN_W-1:0] op_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       cnt_q;
  logic             busy_q;

  assign bcd_adj = add3_nibbles(bcd_q);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      op_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_start) begin
      op_q   <= i_bin;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {bcd_adj[BCD_W-2:0], op_q[BIN_W-1]};
      op_q  <= {op_q[BIN_W-2:0], 1'b0};
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'(BIN_W - 1)) busy_q <= 1'b0;
    end
  end

  assign o_bcd  = bcd_q;
  assign o_done = busy_q && (cnt_q == 4'(BIN_W - 1));

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Converts a binary count to BCD and time-multiplexes the four digits onto one
// code bus with an active-low digit select and leading-zero blanking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int VALUE_W  = 14
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  fnd_scan_ctrl_if.slave  bus,
  input  logic            i_blank,
  output logic [3:0]      o_bcd,
  output logic [3:0]      o_digit_sel,
  output logic            o_sat,
  output state_t          o_dbg_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic             ready_q;
  logic             sat_pend_q;
  logic [BCD_W-1:0] disp_q;
  logic [CW-1:0]    scan_q;
  logic [1:0]       idx_q;

  logic             accept;
  logic             over;
  logic [BIN_W-1:0] operand;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;

  assign accept  = (state_q == IDLE) && bus.i_valid && ready_q;
  assign over    = bus.i_value > VALUE_W'(MAX_VALUE);
  assign operand = over ? BIN_W'(MAX_VALUE) : bus.i_value[BIN_W-1:0];

  bin2bcd_seq u_conv (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (accept),
    .i_bin     (operand),
    .o_bcd     (conv_bcd),
    .o_done    (conv_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (conv_done) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      sat_pend_q <= 1'b0;
      disp_q     <= '0;
      o_sat      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (accept) sat_pend_q <= over;
      if (state_q == LOAD) begin
        disp_q <= conv_bcd;
        o_sat  <= sat_pend_q;
      end
    end
  end

  // Free-running digit scan, unaffected by conversion or blanking.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  logic [3:0] cur_digit;
  logic [3:0] lead_zero;
  logic       digit_blank;

  always_comb begin
    cur_digit    = disp_q[4*idx_q +: 4];
    lead_zero[3] = (disp_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    digit_blank  = lead_zero[idx_q];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_blank) begin
      o_digit_sel <= 4'b1111;
      o_bcd       <= BLANK_CODE;
    end else begin
      o_digit_sel <= ~(4'b0001 << idx_q);
      o_bcd       <= digit_blank ? BLANK_CODE : cur_digit;
    end
  end

  assign bus.o_ready = ready_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV = 4: reset, conversion, saturation,
// busy-drop, blanking and mid-conversion reset.
module tb_fnd_scan_ctrl;
  import fnd_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int VALUE_W  = 14;

  logic       clk;
  logic       reset_n;
  logic       blank;
  logic [3:0] bcd;
  logic [3:0] digit_sel;
  logic       sat;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  fnd_scan_ctrl_if #(.VALUE_W(VALUE_W)) bus ();

  fnd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .VALUE_W(VALUE_W)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .bus         (bus),
    .i_blank     (blank),
    .o_bcd       (bcd),
    .o_digit_sel (digit_sel),
    .o_sat       (sat),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   16'(digit_sel),   16'h000f);
    check({tag, "_bcd"},   16'(bcd),         16'h000f);
    check({tag, "_ready"}, 16'(bus.o_ready), 16'h0000);
    check({tag, "_sat"},   16'(sat),         16'h0000);
    check({tag, "_state"}, 16'(dbg_state),   16'(IDLE));
  endtask

  // Returns at the first negedge where the ones-digit slot is on the outputs.
  task automatic sync_digit0(input string tag);
    int n;
    n = 0;
    while (digit_sel == 4'b1110 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (digit_sel != 4'b1110 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_sync"}, 16'(digit_sel), 16'h000e);
  endtask

  task automatic check_frame(input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3,
                             input logic exp_sat, input string tag);
    logic [3:0] exp_d [4];
    logic [3:0] exp_sel;
    exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
    sync_digit0(tag);
    for (int k = 0; k < 4; k++) begin
      exp_sel = 4'b1111 ^ (4'b0001 << k);
      check($sformatf("%s_d%0d_sel_first", tag, k), 16'(digit_sel), 16'(exp_sel));
      check($sformatf("%s_d%0d_bcd_first", tag, k), 16'(bcd),       16'(exp_d[k]));
      repeat (SCAN_DIV - 1) @(negedge clk);
      check($sformatf("%s_d%0d_sel_last", tag, k),  16'(digit_sel), 16'(exp_sel));
      check($sformatf("%s_d%0d_bcd_last", tag, k),  16'(bcd),       16'(exp_d[k]));
      @(negedge clk);
    end
    check({tag, "_sat"}, 16'(sat), 16'(exp_sat));
  endtask

  // driver tasks
  task automatic send_start(input logic [VALUE_W-1:0] v, input string tag);
    int n;
    n = 0;
    while (!bus.o_ready && n < 40) begin @(negedge clk); n++; end
    check({tag, "_ready_pre"}, 16'(bus.o_ready), 16'h0001);
    bus.i_value = v;
    bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check({tag, "_ready_fall"}, 16'(bus.o_ready), 16'h0000);
    check({tag, "_state_conv"}, 16'(dbg_state),   16'(CONV));
  endtask

  task automatic wait_ready(input int exp_low, input string tag);
    int n;
    n = 0;
    while (!bus.o_ready && n < 40) begin @(negedge clk); n++; end
    check({tag, "_busy_cycles"}, 16'(n), 16'(exp_low));
  endtask

  task automatic send(input logic [VALUE_W-1:0] v, input string tag);
    send_start(v, tag);
    wait_ready(15, tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    blank       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_value = '0;

    // Reset state and first edge after release
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 16'(bus.o_ready), 16'h0001);
    check("rel_sel",   16'(digit_sel),   16'h000e);
    check("rel_bcd",   16'(bcd),         16'h0000);
    check_frame(4'h0, 4'hf, 4'hf, 4'hf, 1'b0, "idle0");

    // Plain conversion
    send(14'd1234, "v1234");
    check_frame(4'h4, 4'h3, 4'h2, 4'h1, 1'b0, "f1234");

    // Blanking for 10 cycles starting inside the ones-digit slot
    sync_digit0("blank");
    blank = 1'b1;
    @(negedge clk);
    check("blank_first_sel", 16'(digit_sel), 16'h000f);
    check("blank_first_bcd", 16'(bcd),       16'h000f);
    repeat (9) @(negedge clk);
    check("blank_last_sel",  16'(digit_sel), 16'h000f);
    check("blank_last_bcd",  16'(bcd),       16'h000f);
    blank = 1'b0;
    @(negedge clk);
    check("unblank_sel_d2",  16'(digit_sel), 16'h000b);
    check("unblank_bcd_d2",  16'(bcd),       16'h0002);
    @(negedge clk);
    check("unblank_sel_d3",  16'(digit_sel), 16'h0007);
    check("unblank_bcd_d3",  16'(bcd),       16'h0001);

    // Saturation and its boundary
    send(14'd10000, "v10000");
    check_frame(4'h9, 4'h9, 4'h9, 4'h9, 1'b1, "f10000");
    send(14'd9999, "v9999");
    check_frame(4'h9, 4'h9, 4'h9, 4'h9, 1'b0, "f9999");

    // Value offered while busy is dropped
    send_start(14'd7, "v7");
    repeat (3) @(negedge clk);
    bus.i_value = 14'd50;
    bus.i_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_valid = 1'b0;
    wait_ready(10, "v7");
    check_frame(4'h7, 4'hf, 4'hf, 4'hf, 1'b0, "f7");
    send(14'd50, "v50");
    check_frame(4'h0, 4'h5, 4'hf, 4'hf, 1'b0, "f50");

    // Reset five cycles into a conversion
    send_start(14'd4321, "v4321");
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    @(negedge clk);
    check("midrel_ready", 16'(bus.o_ready), 16'h0001);
    check("midrel_sel",   16'(digit_sel),   16'h000e);
    check("midrel_bcd",   16'(bcd),         16'h0000);
    check_frame(4'h0, 4'hf, 4'hf, 4'hf, 1'b0, "fpostreset");
    send(14'd5678, "v5678");
    check_frame(4'h8, 4'h7, 4'h6, 4'h5, 1'b0, "f5678");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

- Sits directly upstream of the BCD-to-FND font decoder in the timer display path.
- Accepts a binary count (0–9999) from the timer FSM over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble.
- Time-multiplexes the four digits onto a single 4-bit code bus (`o_bcd`, feeds the decoder's `i_Fnd`) plus an active-low digit-select.
- Suppresses leading zeros with the blank code 4'hf, which the decoder renders as all segments off.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range ≥ 2.
- VALUE_W, 14: width of `i_value`.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_value  in  VALUE_W  binary value to display
- i_valid  in  1  `i_value` is valid
- o_ready  out  1  block can accept a new value
- i_blank  in  1  force whole display dark
- o_bcd  out  4  digit code to decoder (0–9, or 4'hf = blank)
- o_digit_sel  out  4  one-hot active-low digit enable; bit 0 = ones digit
- o_sat  out  1  displayed value was clamped from a value > 9999

## Operation
- Conversion FSM has three states: IDLE, CONV, LOAD.
- IDLE → CONV on `i_valid && o_ready`. At that edge:
  - the operand register captures min(`i_value`, 9999);
  - the saturation flag captures (`i_value` > 9999);
  - the shift counter is cleared.
- CONV runs exactly 14 cycles. Each cycle applies add-3 to every BCD nibble ≥ 5, then shifts one operand bit (MSB first) into the BCD register.
- CONV → LOAD when the shift counter reaches 13. LOAD copies the 16-bit BCD register into the display register and the saturation flag into `o_sat`. LOAD → IDLE.
- `i_valid` outside IDLE is ignored; there is no queuing.
- The previous value stays on the display until LOAD.
- Scan counter: counts 0..SCAN_DIV-1 and wraps. On wrap, the digit index advances 0→1→2→3→0.
- The scan is free-running and independent of conversion.
- Blanking rule: digit k (k = 1..3) is blank when display digits k..3 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Output registers update every cycle from the current index and display register:
  - `o_digit_sel` = ~(1 << idx);
  - `o_bcd` = the digit, or 4'hf when blanked.
- `i_blank` high: `o_digit_sel` = 4'b1111 and `o_bcd` = 4'hf on the next edge. Scan and conversion continue unaffected.

## Timing
- Reset (`i_reset_n` low at an edge) sets:
  - state = IDLE; idx = 0; scan counter = 0;
  - display register = 16'h0000; `o_sat` = 0; `o_ready` = 0;
  - `o_digit_sel` = 4'b1111; `o_bcd` = 4'hf.
- First edge after reset release:
  - `o_ready` = 1;
  - `o_digit_sel` = 4'b1110, `o_bcd` = 4'h0.
- `o_ready` is registered, equal to (next state == IDLE). It falls on the accept edge and rises on the LOAD edge.
- Accept edge = cycle 0. LOAD executes at edge 15; the new digit appears on `o_bcd` at edge 16 at the earliest. Minimum spacing between accepts is 16 cycles.
- Output latency from idx/display change to `o_bcd`/`o_digit_sel` is one cycle.
- Reset mid-conversion aborts: the partial result is discarded and the display reads 0.
- Each digit slot lasts exactly SCAN_DIV cycles. A full frame is 4×SCAN_DIV cycles.
- A display change mid-slot takes effect at the next output-register edge. No glitch beyond one code change per edge.

## Structure
- Shared package `fnd_pkg`:
  - state enum (IDLE/CONV/LOAD);
  - constants NUM_DIGITS = 4, BLANK_CODE = 4'hf, MAX_VALUE = 9999, BCD_W = 16.
- Sub-module `bin2bcd_seq` (start/done, 14-bit in, 16-bit out, iterative double-dabble) holds the CONV datapath.
- The top level holds the handshake, display register, scan counter, blanking and output registers.

## Test plan
Run with SCAN_DIV = 4.
- Reset, release, no input → `o_ready` = 1 at edge 1. `o_digit_sel` cycles 1110/1101/1011/0111 every 4 cycles. `o_bcd` = 0, f, f, f.
- Send 1234 → `o_ready` low for 15 cycles. Afterwards `o_bcd` = 4, 3, 2, 1 in index order; `o_sat` = 0.
- Send 10000, then 9999 → first shows 9, 9, 9, 9 with `o_sat` = 1. Second shows 9, 9, 9, 9 with `o_sat` = 0.
- Send 7 then 50 (second while busy, then again after ready) → busy pulse ignored. Final display is 0, 5, f, f.
- Assert `i_blank` for 10 cycles during 1234 display → `o_digit_sel` = 1111 and `o_bcd` = f, then the scan resumes at the index reached meanwhile.
- Assert reset 5 cycles into converting 4321 → all outputs at reset values. After release the display shows 0 and the next accept works.
